pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: program counter with increment, absolute jump, relative branch
// and an optional call/return stack.
//
// Build option: define PC_RETURN_STACK_EN to compile in the return stack.
// Without it, call behaves as jmp, ret is ignored, and the stack status
// outputs are tied to full=0, empty=1, err=0.
//
// Parameters: WIDTH (pc/target/offset bits), STEP (sequential increment),
//             DEPTH (return-stack entries, 2..16), RESET_VEC (pc after reset)
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              advance enable (0 = stall: pc held, no stack activity)
//   jmp, br         absolute jump to target / relative branch by offset
//   call, ret       push return address and jump / pop into pc
//   target, offset  absolute destination / signed displacement
//   pc, pc_next     registered program counter / value pc takes next edge
//   stack_full, stack_empty, stack_err
//                   registered stack status; err pulses one cycle after an
//                   overflowing call or an underflowing ret
module pc_unit #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jmp,
    input  logic             br,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_br;

    assign pc_inc = pc + STEP_W;
    // Same-width two's-complement add is already the sign-extended sum mod 2^WIDTH.
    assign pc_br  = pc + offset;

`ifdef PC_RETURN_STACK_EN

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [IW-1:0]    top_idx;
    logic             push;
    logic             err_next;

    assign top_idx = IW'(count - CW'(1));

    always_comb begin
        pc_next    = pc;
        count_next = count;
        push       = 1'b0;
        err_next   = 1'b0;
        if (rst) begin
            pc_next = RESET_W;
        end else if (en) begin
            if (ret) begin
                if (count != '0) begin
                    pc_next    = stack_mem[top_idx];
                    count_next = count - CW'(1);
                end else begin
                    // Underflow falls back to a plain increment.
                    pc_next  = pc_inc;
                    err_next = 1'b1;
                end
            end else if (call) begin
                pc_next = target;
                if (count != CW'(DEPTH)) begin
                    push       = 1'b1;
                    count_next = count + CW'(1);
                end else begin
                    // Overflow still jumps; the return address is lost.
                    err_next = 1'b1;
                end
            end else if (jmp) begin
                pc_next = target;
            end else if (br) begin
                pc_next = pc_br;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_W;
            count       <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            pc          <= pc_next;
            count       <= count_next;
            stack_empty <= (count_next == '0);
            stack_full  <= (count_next == CW'(DEPTH));
            stack_err   <= err_next;
        end
    end

    // Storage is not reset; entries above count are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[count[IW-1:0]] <= pc_inc;
        end
    end

`else

    logic unused_ret;
    assign unused_ret = ret;

    always_comb begin
        pc_next = pc;
        if (rst) begin
            pc_next = RESET_W;
        end else if (en) begin
            if (call || jmp) begin
                pc_next = target;
            end else if (br) begin
                pc_next = pc_br;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_W;
        end else begin
            pc <= pc_next;
        end
    end

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;

`endif

endmodule
